// File: rtl/eth_link_pkg.sv
// Shared types and packing helpers for the multi-lane 10GBASE-R link supervisor.
package eth_link_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_UP        = 3'd4,
    ST_RX_RESET  = 3'd5,
    ST_FAILED    = 3'd6
  } lane_state_e;

  localparam int STATE_W     = 3;
  localparam int RETRY_WIDTH = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bit offset of a lane's field inside the packed lane_state vector.
  function automatic int state_off(input int lane);
    return lane * STATE_W;
  endfunction

  // Bit offset of a lane's field inside the packed retry_count vector.
  function automatic int retry_off(input int lane);
    return lane * RETRY_WIDTH;
  endfunction

  // Bit offset of a lane's field inside the packed drop_count vector.
  function automatic int drop_off(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/eth_link_lane.sv
// One supervised lane: input synchronisers, shared state timer, retry and
// drop counters, and the reset/recovery state machine.
module eth_link_lane
  import eth_link_pkg::*;
#(
  parameter int RESET_CYCLES    = 1024,
  parameter int DONE_TIMEOUT    = 65536,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int LOSS_FILTER     = 256,
  parameter int RX_RESET_CYCLES = 16,
  parameter int MAX_RETRIES     = 7,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   tx_done_i,
  input  logic                   rx_done_i,
  input  logic                   lock_i,
  output logic                   gt_reset_all_o,
  output logic                   gt_reset_rx_o,
  output logic                   link_up_o,
  output logic                   link_failed_o,
  output logic [STATE_W-1:0]     state_o,
  output logic [RETRY_WIDTH-1:0] retry_o,
  output logic [CNT_WIDTH-1:0]   drop_o
);

  localparam int TMAX = max2(max2(max2(RESET_CYCLES, DONE_TIMEOUT),
                                  max2(LOCK_TIMEOUT, LOSS_FILTER)),
                             RX_RESET_CYCLES);
  localparam int TW = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] LOSS_LAST  = TW'(LOSS_FILTER - 1);
  localparam logic [TW-1:0] RXR_LAST   = TW'(RX_RESET_CYCLES - 1);
  // With MAX_RETRIES=15 the limit wraps to 0, which still matches the
  // wrapped increment 15+1, so the full 4-bit range stays usable.
  localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES + 1);

  lane_state_e            state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d, retry_inc;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [2:0]             sync1_q, sync2_q;
  logic                   gt_reset_all_q, gt_reset_rx_q, link_up_q, link_failed_q;
  logic                   done_s, lock_s, drop_evt;

  assign done_s    = sync2_q[0] & sync2_q[1];
  assign lock_s    = sync2_q[2];
  assign retry_inc = retry_q + 1'b1;

  // Two-flop synchronisers for the asynchronous GT and PHY status inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {lock_i, rx_done_i, tx_done_i};
      sync2_q <= sync1_q;
    end
  end

  // Next-state, timer and counter decisions; enable low overrides everything.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    retry_d  = retry_q;
    drop_d   = drop_q;
    drop_evt = 1'b0;
    case (state_q)
      ST_DISABLED:  if (enable_i) state_d = ST_RESET;
      ST_RESET:     if (timer_q == RESET_LAST) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == DONE_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? ST_FAILED : ST_RESET;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_UP;
          retry_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? ST_FAILED : ST_RX_RESET;
        end
      end
      ST_UP: begin
        if (lock_s) begin
          timer_d = '0;
        end else if (timer_q == LOSS_LAST) begin
          drop_evt = 1'b1;
          state_d  = ST_RX_RESET;
        end
      end
      ST_RX_RESET:  if (timer_q == RXR_LAST) state_d = ST_WAIT_DONE;
      ST_FAILED:    state_d = ST_FAILED;
      default:      state_d = ST_RESET;
    endcase
    if (!enable_i) begin
      state_d = ST_DISABLED;
      retry_d = '0;
    end
    if (drop_evt && enable_i && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (clear_i) begin
      drop_d  = '0;
      retry_d = '0;
    end
    if ((state_d != state_q) || (state_q == ST_DISABLED) || (state_q == ST_FAILED))
      timer_d = '0;
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_RESET;
      timer_q        <= '0;
      retry_q        <= '0;
      drop_q         <= '0;
      gt_reset_all_q <= 1'b1;
      gt_reset_rx_q  <= 1'b0;
      link_up_q      <= 1'b0;
      link_failed_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      drop_q         <= drop_d;
      gt_reset_all_q <= (state_d == ST_DISABLED) || (state_d == ST_RESET) ||
                        (state_d == ST_FAILED);
      gt_reset_rx_q  <= (state_d == ST_RX_RESET);
      link_up_q      <= (state_d == ST_UP);
      link_failed_q  <= (state_d == ST_FAILED);
    end
  end

  assign gt_reset_all_o = gt_reset_all_q;
  assign gt_reset_rx_o  = gt_reset_rx_q;
  assign link_up_o      = link_up_q;
  assign link_failed_o  = link_failed_q;
  assign state_o        = state_q;
  assign retry_o        = retry_q;
  assign drop_o         = drop_q;

endmodule

// File: rtl/eth_link_supervisor.sv
// Multi-lane link supervisor: one independent eth_link_lane per lane, with
// per-lane results packed into flat output vectors.
module eth_link_supervisor
  import eth_link_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int RESET_CYCLES    = 1024,
  parameter int DONE_TIMEOUT    = 65536,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int LOSS_FILTER     = 256,
  parameter int RX_RESET_CYCLES = 16,
  parameter int MAX_RETRIES     = 7,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES-1:0]           enable,
  input  logic                           clear_counters,
  input  logic [NUM_LANES-1:0]           gt_tx_done,
  input  logic [NUM_LANES-1:0]           gt_rx_done,
  input  logic [NUM_LANES-1:0]           rx_block_lock,
  output logic [NUM_LANES-1:0]           gt_reset_all,
  output logic [NUM_LANES-1:0]           gt_reset_rx_datapath,
  output logic [NUM_LANES-1:0]           link_up,
  output logic [NUM_LANES-1:0]           link_failed,
  output logic [STATE_W*NUM_LANES-1:0]   lane_state,
  output logic [RETRY_WIDTH*NUM_LANES-1:0] retry_count,
  output logic [CNT_WIDTH*NUM_LANES-1:0] drop_count
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    eth_link_lane #(
      .RESET_CYCLES    (RESET_CYCLES),
      .DONE_TIMEOUT    (DONE_TIMEOUT),
      .LOCK_TIMEOUT    (LOCK_TIMEOUT),
      .LOSS_FILTER     (LOSS_FILTER),
      .RX_RESET_CYCLES (RX_RESET_CYCLES),
      .MAX_RETRIES     (MAX_RETRIES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_lane (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable[i]),
      .clear_i        (clear_counters),
      .tx_done_i      (gt_tx_done[i]),
      .rx_done_i      (gt_rx_done[i]),
      .lock_i         (rx_block_lock[i]),
      .gt_reset_all_o (gt_reset_all[i]),
      .gt_reset_rx_o  (gt_reset_rx_datapath[i]),
      .link_up_o      (link_up[i]),
      .link_failed_o  (link_failed[i]),
      .state_o        (lane_state[state_off(i) +: STATE_W]),
      .retry_o        (retry_count[retry_off(i) +: RETRY_WIDTH]),
      .drop_o         (drop_count[drop_off(i, CNT_WIDTH) +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Directed checks of the link supervisor with two lanes and short timers.
module tb_eth_link_supervisor;

  localparam int NL = 2;
  localparam int CW = 2;

  logic            clock;
  logic            reset;
  logic [NL-1:0]   enable;
  logic            clearCounters;
  logic [NL-1:0]   txDone, rxDone, blockLock;
  logic [NL-1:0]   gtResetAll, gtResetRx, linkUp, linkFailed;
  logic [3*NL-1:0] laneState;
  logic [4*NL-1:0] retryCount;
  logic [CW*NL-1:0] dropCount;

  int vectorCount = 0;
  int missCount   = 0;

  eth_link_supervisor #(
    .NUM_LANES       (NL),
    .RESET_CYCLES    (8),
    .DONE_TIMEOUT    (32),
    .LOCK_TIMEOUT    (32),
    .LOSS_FILTER     (4),
    .RX_RESET_CYCLES (4),
    .MAX_RETRIES     (2),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk                  (clock),
    .rst                  (reset),
    .enable               (enable),
    .clear_counters       (clearCounters),
    .gt_tx_done           (txDone),
    .gt_rx_done           (rxDone),
    .rx_block_lock        (blockLock),
    .gt_reset_all         (gtResetAll),
    .gt_reset_rx_datapath (gtResetRx),
    .link_up              (linkUp),
    .link_failed          (linkFailed),
    .lane_state           (laneState),
    .retry_count          (retryCount),
    .drop_count           (dropCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the directed sequence never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance a number of rising edges and land 1 ns after the last one.
  task automatic applyStimulus(input int edges);
    repeat (edges) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence; comments give the edge count since reset release.
  initial begin
    reset = 1'b1; enable = 2'b11; clearCounters = 1'b0;
    txDone = 2'b00; rxDone = 2'b00; blockLock = 2'b00;
    #1;
    checkOutput("rst_gt_reset_all", gtResetAll, 2'b11);
    checkOutput("rst_rx_reset",     gtResetRx,  2'b00);
    checkOutput("rst_link_up",      linkUp,     2'b00);
    checkOutput("rst_link_failed",  linkFailed, 2'b00);
    checkOutput("rst_state",        laneState,  {3'd1, 3'd1});
    checkOutput("rst_retry",        retryCount, 8'h00);
    checkOutput("rst_drop",         dropCount,  4'h0);
    #11 reset = 1'b0;

    // Bring-up: RESET for 8 edges, status asserted after edge 19.
    applyStimulus(7);
    checkOutput("bu_reset_held_e7", gtResetAll, 2'b11);
    applyStimulus(1);
    checkOutput("bu_reset_low_e8", gtResetAll, 2'b00);
    checkOutput("bu_wait_done_e8", laneState, {3'd2, 3'd2});
    applyStimulus(11);
    txDone = 2'b11; rxDone = 2'b11; blockLock = 2'b11;
    applyStimulus(2);
    checkOutput("bu_sync_e21", laneState, {3'd2, 3'd2});
    applyStimulus(1);
    checkOutput("bu_wait_lock_e22", laneState, {3'd3, 3'd3});
    applyStimulus(1);
    checkOutput("bu_up_e23", laneState, {3'd4, 3'd4});
    checkOutput("bu_link_up_e23", linkUp, 2'b11);
    checkOutput("bu_retry_e23", retryCount, 8'h00);

    // Lane 0 lock glitch of 3 cycles: filtered.
    blockLock = 2'b10;
    applyStimulus(3);
    blockLock = 2'b11;
    applyStimulus(6);
    checkOutput("gl_link_up_e32", linkUp, 2'b11);
    checkOutput("gl_drop_e32", dropCount, 4'h0);

    // Lane 0 lock lost for 4 cycles: drop, 4-cycle RX datapath reset.
    blockLock = 2'b10;
    applyStimulus(4);
    blockLock = 2'b11;
    applyStimulus(2);
    checkOutput("dr_state_e38", laneState, {3'd4, 3'd5});
    checkOutput("dr_drop_e38", dropCount, 4'b0001);
    checkOutput("dr_rx_reset_e38", gtResetRx, 2'b01);
    checkOutput("dr_link_up_e38", linkUp, 2'b10);
    applyStimulus(3);
    checkOutput("dr_rx_reset_e41", gtResetRx, 2'b01);
    applyStimulus(1);
    checkOutput("dr_rx_reset_end_e42", gtResetRx, 2'b00);
    checkOutput("dr_wait_done_e42", laneState, {3'd4, 3'd2});
    applyStimulus(2);
    checkOutput("dr_recovered_e44", laneState, {3'd4, 3'd4});

    // Clear in the same cycle as the drop increment (edge 50).
    blockLock = 2'b10;
    applyStimulus(4);
    blockLock = 2'b11;
    applyStimulus(1);
    clearCounters = 1'b1;
    applyStimulus(1);
    clearCounters = 1'b0;
    checkOutput("clr_state_e50", laneState, {3'd4, 3'd5});
    checkOutput("clr_drop_e50", dropCount, 4'b0000);
    applyStimulus(6);
    checkOutput("clr_recovered_e56", laneState, {3'd4, 3'd4});

    // Four more drops on lane 0: 2-bit counter saturates at 3.
    for (int k = 0; k < 4; k++) begin
      blockLock = 2'b10;
      applyStimulus(4);
      blockLock = 2'b11;
      applyStimulus(8);
      if (k == 2) checkOutput("sat_drop_after3", dropCount, 4'b0011);
    end
    checkOutput("sat_drop_after4", dropCount, 4'b0011);
    checkOutput("sat_state", laneState, {3'd4, 3'd4});

    // Reset asserted while both lanes are UP.
    reset = 1'b1;
    #1;
    checkOutput("rr_gt_reset_all", gtResetAll, 2'b11);
    checkOutput("rr_link_up", linkUp, 2'b00);
    checkOutput("rr_state", laneState, {3'd1, 3'd1});
    checkOutput("rr_drop", dropCount, 4'h0);
    checkOutput("rr_retry", retryCount, 8'h00);
    applyStimulus(1);
    blockLock = 2'b10;
    reset = 1'b0;

    // Lock timeout on lane 0; lane 1 comes up normally.
    applyStimulus(40);
    checkOutput("lt_wait_lock_e40", laneState, {3'd4, 3'd3});
    checkOutput("lt_retry0_e40", retryCount, 8'h00);
    applyStimulus(1);
    checkOutput("lt_rx_reset_e41", laneState, {3'd4, 3'd5});
    checkOutput("lt_retry1_e41", retryCount, 8'h01);
    checkOutput("lt_rx_pulse_e41", gtResetRx, 2'b01);
    applyStimulus(36);
    checkOutput("lt_wait_lock_e77", laneState, {3'd4, 3'd3});
    applyStimulus(1);
    checkOutput("lt_rx_reset_e78", laneState, {3'd4, 3'd5});
    checkOutput("lt_retry2_e78", retryCount, 8'h02);
    applyStimulus(36);
    checkOutput("lt_wait_lock_e114", laneState, {3'd4, 3'd3});
    checkOutput("lt_not_failed_e114", linkFailed, 2'b00);
    applyStimulus(1);
    checkOutput("lt_failed_e115", laneState, {3'd4, 3'd6});
    checkOutput("lt_link_failed_e115", linkFailed, 2'b01);
    checkOutput("lt_retry3_e115", retryCount, 8'h03);
    checkOutput("lt_gt_reset_e115", gtResetAll, 2'b01);

    // Enable low then high on lane 0 leaves FAILED and clears retry.
    enable = 2'b10;
    applyStimulus(1);
    checkOutput("en_disabled", laneState, {3'd4, 3'd0});
    checkOutput("en_retry_cleared", retryCount, 8'h00);
    checkOutput("en_failed_cleared", linkFailed, 2'b00);
    checkOutput("en_gt_reset", gtResetAll, 2'b01);
    enable = 2'b11;
    applyStimulus(1);
    checkOutput("en_reset", laneState, {3'd4, 3'd1});
    txDone = 2'b10;

    // Done timeout on lane 0: 8-cycle reset, 32-cycle wait, repeat.
    applyStimulus(7);
    checkOutput("dt_reset_r7", gtResetAll, 2'b01);
    applyStimulus(1);
    checkOutput("dt_reset_low_r8", gtResetAll, 2'b00);
    checkOutput("dt_wait_done_r8", laneState, {3'd4, 3'd2});
    applyStimulus(31);
    checkOutput("dt_wait_done_r39", laneState, {3'd4, 3'd2});
    applyStimulus(1);
    checkOutput("dt_reset_r40", laneState, {3'd4, 3'd1});
    checkOutput("dt_gt_reset_r40", gtResetAll, 2'b01);
    checkOutput("dt_retry_r40", retryCount, 8'h01);
    applyStimulus(7);
    checkOutput("dt_gt_reset_r47", gtResetAll, 2'b01);
    applyStimulus(1);
    checkOutput("dt_gt_reset_low_r48", gtResetAll, 2'b00);
    checkOutput("dt_wait_done_r48", laneState, {3'd4, 3'd2});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
